v2f_seq_udiv32: RTL and testbench

- Multi-cycle unsigned 32/32 divider. Produces quotient and remainder.
- Target for lowered unsigned `$div`/`$mod` cells whose combinational lowering is too costly in combinators.
- Datapath uses only 32-bit signed-friendly operations: add, subtract, shift, and signed compare with the 0x80000000 bias trick. No 33-bit or wider intermediate survives mapping.
- Sits downstream of the simplify techmap pass; `Q`/`R` feed ordinary 32-bit logic.

---
 rtl/v2f_div_pkg.sv | 18 +
 rtl/v2f_udiv_step.sv | 29 ++
 rtl/v2f_seq_udiv32.sv | 125 ++++++++++++
 tb/tb_v2f_seq_udiv32.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v2f_div_pkg.sv
// Shared types and constants for the sequential unsigned 32/32 divider.
// The iteration-count helper keeps the top and its users in agreement on cycle counts.
package v2f_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Adding this bias maps unsigned order onto signed order.
    localparam logic [31:0] BIAS = 32'h8000_0000;

    function automatic int iter_count(input int steps);
        return 32 / steps;
    endfunction

endpackage

// File: rtl/v2f_udiv_step.sv
// One combinational restoring-division step. The full partial remainder is {carry, p},
// so the bit shifted out of the 32-bit remainder is never lost.
module v2f_udiv_step
    import v2f_div_pkg::*;
(
    input  logic [30:0] p,
    input  logic        carry,
    input  logic [31:0] qs,
    input  logic [31:0] b,
    output logic [30:0] p_nxt,
    output logic        carry_nxt,
    output logic [31:0] qs_nxt
);

    logic [31:0] p_sh;
    logic [31:0] p_new;
    logic        take;

    always_comb begin
        p_sh  = {p, qs[31]};
        // A set carry means the shifted remainder is at least 2^32, which always exceeds b.
        take  = carry | ($signed(p_sh + BIAS) >= $signed(b + BIAS));
        p_new = take ? (p_sh - b) : p_sh;
        p_nxt     = p_new[30:0];
        carry_nxt = p_new[31];
        qs_nxt    = {qs[30:0], take};
    end

endmodule

// File: rtl/v2f_seq_udiv32.sv
// Multi-cycle unsigned 32/32 divider: 32/STEPS_PER_CYCLE+1 clocks per result, 1 clock on B==0.
// Single operation in flight; the result is held until OUT_READY, and operands are ignored while busy.
module v2f_seq_udiv32
    import v2f_div_pkg::*;
#(
    parameter int          STEPS_PER_CYCLE = 1,
    parameter logic [31:0] ZERO_Q          = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        ARST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] Q,
    output logic [31:0] R,
    output logic        DIV_ZERO,
    output logic        BUSY
);

    localparam int ITER = iter_count(STEPS_PER_CYCLE);

    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 &&
        STEPS_PER_CYCLE != 4 && STEPS_PER_CYCLE != 8) begin : g_bad_steps
        $error("v2f_seq_udiv32: STEPS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    div_state_t  state, state_nxt;
    logic [31:0] b_r;
    logic [30:0] p_r;
    logic        carry_r;
    logic [31:0] qs_r;
    logic [5:0]  cnt_r;
    logic [31:0] q_r;
    logic [31:0] r_r;
    logic        dz_r;

    logic [30:0] p_ch     [STEPS_PER_CYCLE+1];
    logic        carry_ch [STEPS_PER_CYCLE+1];
    logic [31:0] qs_ch    [STEPS_PER_CYCLE+1];

    assign p_ch[0]     = p_r;
    assign carry_ch[0] = carry_r;
    assign qs_ch[0]    = qs_r;

    for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
        v2f_udiv_step u_step (
            .p         (p_ch[i]),
            .carry     (carry_ch[i]),
            .qs        (qs_ch[i]),
            .b         (b_r),
            .p_nxt     (p_ch[i+1]),
            .carry_nxt (carry_ch[i+1]),
            .qs_nxt    (qs_ch[i+1])
        );
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (IN_VALID) state_nxt = (B == 32'd0) ? DONE : RUN;
            RUN:     if (cnt_r == 6'd1) state_nxt = DONE;
            DONE:    if (OUT_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            b_r     <= '0;
            p_r     <= '0;
            carry_r <= 1'b0;
            qs_r    <= '0;
            cnt_r   <= '0;
            q_r     <= '0;
            r_r     <= '0;
            dz_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        if (B == 32'd0) begin
                            q_r  <= ZERO_Q;
                            r_r  <= A;
                            dz_r <= 1'b1;
                        end else begin
                            b_r     <= B;
                            qs_r    <= A;
                            p_r     <= '0;
                            carry_r <= 1'b0;
                            cnt_r   <= 6'(ITER);
                            dz_r    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    p_r     <= p_ch[STEPS_PER_CYCLE];
                    carry_r <= carry_ch[STEPS_PER_CYCLE];
                    qs_r    <= qs_ch[STEPS_PER_CYCLE];
                    cnt_r   <= cnt_r - 6'd1;
                    if (cnt_r == 6'd1) begin
                        q_r <= qs_ch[STEPS_PER_CYCLE];
                        r_r <= {carry_ch[STEPS_PER_CYCLE], p_ch[STEPS_PER_CYCLE]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign IN_READY  = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign OUT_VALID = (state == DONE);
    assign Q         = q_r;
    assign R         = r_r;
    assign DIV_ZERO  = dz_r;

endmodule

// File: tb/tb_v2f_seq_udiv32.sv
// Bench for the sequential divider: default-width instance plus a 4-steps-per-cycle instance.
// Expected results come from a scoreboard filled with golden A/B and A%B at issue time.
module tb_v2f_seq_udiv32;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic        pos_clk = 1'b0;
    logic        pos_arst;
    logic        iv;
    logic [31:0] a_in, b_in;
    logic        ordy;
    logic        cur4;

    logic        iv1, ir1, ov1, ordy1, dz1, busy1;
    logic [31:0] q1, r1;
    logic        iv4, ir4, ov4, ordy4, dz4, busy4;
    logic [31:0] q4, r4;

    logic        s_ir, s_ov, s_dz, s_busy;
    logic [31:0] s_q, s_r;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 pos_clk = ~pos_clk;

    assign iv1   = iv & ~cur4;
    assign iv4   = iv & cur4;
    assign ordy1 = ordy & ~cur4;
    assign ordy4 = ordy & cur4;

    assign s_ir   = cur4 ? ir4   : ir1;
    assign s_ov   = cur4 ? ov4   : ov1;
    assign s_q    = cur4 ? q4    : q1;
    assign s_r    = cur4 ? r4    : r1;
    assign s_dz   = cur4 ? dz4   : dz1;
    assign s_busy = cur4 ? busy4 : busy1;

    v2f_seq_udiv32 dut (
        .CLK(pos_clk), .ARST(pos_arst),
        .IN_VALID(iv1), .IN_READY(ir1), .A(a_in), .B(b_in),
        .OUT_VALID(ov1), .OUT_READY(ordy1),
        .Q(q1), .R(r1), .DIV_ZERO(dz1), .BUSY(busy1)
    );

    v2f_seq_udiv32 #(.STEPS_PER_CYCLE(4)) dut4 (
        .CLK(pos_clk), .ARST(pos_arst),
        .IN_VALID(iv4), .IN_READY(ir4), .A(a_in), .B(b_in),
        .OUT_VALID(ov4), .OUT_READY(ordy4),
        .Q(q4), .R(r4), .DIV_ZERO(dz4), .BUSY(busy4)
    );

    function automatic exp_t golden(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Issue one operation, record its golden result, and wait for OUT_VALID.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        int n;
        n = 0;
        while (!s_ir && n < 200) begin
            @(posedge pos_clk); #1; n++;
        end
        if (!s_ir) begin
            checks++; errors++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", s_ir);
        end
        sb.push_back(golden(a, b));
        iv = 1'b1; a_in = a; b_in = b;
        @(posedge pos_clk); #1;
        iv = 1'b0;
        lat = 1;
        while (!s_ov && lat < 200) begin
            @(posedge pos_clk); #1; lat++;
        end
        if (!s_ov) begin
            checks++; errors++;
            $display("FAIL out_valid_wait: out_valid=%b required 1 within 200 clocks", s_ov);
        end
    endtask

    task automatic release_out();
        ordy = 1'b1;
        @(posedge pos_clk); #1;
        ordy = 1'b0;
    endtask

    task automatic test_reset();
        pos_arst = 1'b1; iv = 1'b0; ordy = 1'b0; cur4 = 1'b0; a_in = '0; b_in = '0;
        #1;
        checks++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0 || busy1 !== 1'b0 || q1 !== 32'd0 || r1 !== 32'd0 || dz1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ir=%b ov=%b busy=%b q=%h r=%h dz=%b required 1 0 0 0 0 0",
                     ir1, ov1, busy1, q1, r1, dz1);
        end
        checks++;
        if (ir4 !== 1'b1 || ov4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs4: ir=%b ov=%b busy=%b required 1 0 0", ir4, ov4, busy4);
        end
        repeat (2) @(posedge pos_clk);
        #1 pos_arst = 1'b0;
        @(posedge pos_clk); #1;
        checks++;
        if (ir1 !== 1'b1 || busy1 !== 1'b0 || ov1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: ir=%b busy=%b ov=%b required 1 0 0", ir1, busy1, ov1);
        end
    endtask

    task automatic test_basic();
        int lat;
        exp_t e;
        run_op(32'd100, 32'd7, lat);
        e = sb.pop_front();
        checks++;
        if (lat != 33) begin
            errors++; $display("FAIL basic_latency: got %0d required 33", lat);
        end
        checks++;
        if (s_q !== e.q || s_r !== e.r || s_dz !== e.dz || s_q !== 32'd14 || s_r !== 32'd2) begin
            errors++;
            $display("FAIL basic_100_7: q=%0d r=%0d dz=%b required q=%0d r=%0d dz=%b", s_q, s_r, s_dz, e.q, e.r, e.dz);
        end
        checks++;
        if (s_busy !== 1'b1 || s_ir !== 1'b0) begin
            errors++; $display("FAIL done_flags: busy=%b ir=%b required 1 0", s_busy, s_ir);
        end
        release_out();
    endtask

    task automatic test_extremes();
        int lat;
        exp_t e;
        logic [31:0] av [3];
        logic [31:0] bv [3];
        av[0] = 32'hFFFF_FFFF; bv[0] = 32'd1;
        av[1] = 32'h8000_0000; bv[1] = 32'hFFFF_FFFF;
        av[2] = 32'hFFFF_FFFE; bv[2] = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], lat);
            e = sb.pop_front();
            checks++;
            if (lat != 33 || s_q !== e.q || s_r !== e.r || s_dz !== e.dz) begin
                errors++;
                $display("FAIL extreme_%0d: lat=%0d q=%h r=%h dz=%b required lat=33 q=%h r=%h dz=%b",
                         i, lat, s_q, s_r, s_dz, e.q, e.r, e.dz);
            end
            release_out();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        exp_t e;
        run_op(32'd5, 32'd0, lat);
        e = sb.pop_front();
        checks++;
        if (lat != 1 || s_q !== 32'hFFFF_FFFF || s_r !== 32'd5 || s_dz !== 1'b1) begin
            errors++;
            $display("FAIL div_zero: lat=%0d q=%h r=%0d dz=%b required lat=1 q=%h r=%0d dz=%b",
                     lat, s_q, s_r, s_dz, e.q, e.r, e.dz);
        end
        release_out();
        run_op(32'd9, 32'd3, lat);
        e = sb.pop_front();
        checks++;
        if (s_q !== e.q || s_r !== e.r || s_dz !== 1'b0) begin
            errors++;
            $display("FAIL after_div_zero: q=%0d r=%0d dz=%b required q=%0d r=%0d dz=0", s_q, s_r, s_dz, e.q, e.r);
        end
        release_out();
    endtask

    task automatic test_hold();
        int lat;
        exp_t e;
        int bad;
        run_op(32'd20, 32'd6, lat);
        e = sb.pop_front();
        checks++;
        if (s_q !== e.q || s_r !== e.r) begin
            errors++; $display("FAIL hold_first: q=%0d r=%0d required q=%0d r=%0d", s_q, s_r, e.q, e.r);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            iv = 1'b1; a_in = 32'd1; b_in = 32'd1;
            @(posedge pos_clk); #1;
            if (s_q !== e.q || s_r !== e.r || s_dz !== e.dz || s_ir !== 1'b0 || s_ov !== 1'b1) bad++;
        end
        iv = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d disturbed cycles (q=%0d r=%0d ir=%b ov=%b) required 0", bad, s_q, s_r, s_ir, s_ov);
        end
        release_out();
        checks++;
        if (s_ir !== 1'b1 || s_busy !== 1'b0 || s_ov !== 1'b0) begin
            errors++; $display("FAIL hold_release: ir=%b busy=%b ov=%b required 1 0 0", s_ir, s_busy, s_ov);
        end
        run_op(32'd1, 32'd1, lat);
        e = sb.pop_front();
        checks++;
        if (s_q !== e.q || s_r !== e.r || s_q !== 32'd1) begin
            errors++; $display("FAIL hold_next_op: q=%0d r=%0d required q=%0d r=%0d", s_q, s_r, e.q, e.r);
        end
        release_out();
    endtask

    task automatic test_arst_abort();
        int lat;
        exp_t e;
        iv = 1'b1; a_in = 32'd1000; b_in = 32'd3;
        @(posedge pos_clk); #1;
        iv = 1'b0;
        repeat (10) @(posedge pos_clk);
        #1 pos_arst = 1'b1;
        #1;
        checks++;
        if (ov1 !== 1'b0 || busy1 !== 1'b0 || q1 !== 32'd0 || r1 !== 32'd0 || ir1 !== 1'b1 || dz1 !== 1'b0) begin
            errors++;
            $display("FAIL arst_abort: ov=%b busy=%b q=%0d r=%0d ir=%b dz=%b required 0 0 0 0 1 0",
                     ov1, busy1, q1, r1, ir1, dz1);
        end
        #2 pos_arst = 1'b0;
        run_op(32'd1000, 32'd3, lat);
        e = sb.pop_front();
        checks++;
        if (lat != 33 || s_q !== e.q || s_r !== e.r || s_q !== 32'd333 || s_r !== 32'd1) begin
            errors++;
            $display("FAIL arst_recover: lat=%0d q=%0d r=%0d required lat=33 q=%0d r=%0d", lat, s_q, s_r, e.q, e.r);
        end
        release_out();
    endtask

    task automatic test_random4();
        int lat;
        int exp_lat;
        exp_t e;
        logic [31:0] a, b;
        cur4 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 1000);
                1:       b = a >> $urandom_range(0, 31);
                2:       b = (i % 50 == 0) ? 32'd0 : $urandom;
                default: b = $urandom;
            endcase
            exp_lat = (b == 32'd0) ? 1 : 9;
            run_op(a, b, lat);
            e = sb.pop_front();
            checks++;
            if (lat != exp_lat || s_q !== e.q || s_r !== e.r || s_dz !== e.dz) begin
                errors++;
                $display("FAIL random4_%0d: a=%h b=%h lat=%0d q=%h r=%h dz=%b required lat=%0d q=%h r=%h dz=%b",
                         i, a, b, lat, s_q, s_r, s_dz, exp_lat, e.q, e.r, e.dz);
            end
            release_out();
        end
        cur4 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_hold();
        test_arst_abort();
        test_random4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
